// File: rtl/dm_responder.sv
// dm_responder: data-memory target for the CPU load/store port.
//
// Each transaction is a single 32-bit read or write. The responder
// inserts WAIT_CYCLES wait states, performs a byte-enabled RAM access,
// and then returns a one-cycle ack together with read data and an
// error flag.
//
// Optional build macro: DM_UNALIGNED_ERR_EN
//   defined   -> a byte address with address[1:0] != 0 is rejected like
//                an out-of-range access (no RAM access, err=1,
//                data_out=0).
//   undefined -> address[1:0] is ignored and the access goes to the
//                containing word.
//
// The FSM state is visible on dbg_state_o (0=IDLE, 1=WAIT, 2=RESP) so
// that checkers can bind to it.

module dm_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [3:0]  byte_en,
    output logic        ready,
    output logic        ack,
    output logic [31:0] data_out,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a request is accepted on a rising edge where req=1 and
    // ready=1. we/address/data_in/byte_en are sampled on that edge only.
    // While ready=0 the request is neither accepted nor queued; the
    // initiator keeps req asserted until it sees ready. Completion is
    // signalled by ack=1 for exactly one cycle, with err and data_out
    // valid in that same cycle.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Counter load value on acceptance. WAIT remains active for
    // WAIT_CYCLES cycles: the counter is loaded with WAIT_CYCLES-1 and
    // the FSM leaves WAIT on the edge where the counter reads zero.
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] data_q,  data_d;
    logic        err_q,   err_d;

    // Request fields captured on acceptance.
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Storage array. It is deliberately not reset.
    logic [31:0] mem [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Access-side signals
    // ------------------------------------------------------------------
    // With WAIT_CYCLES=0 the RAM access happens on the acceptance edge
    // itself, before the request registers have loaded. The live inputs
    // are therefore used while in IDLE and the latched copy otherwise.
    logic                  in_idle;
    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  range_err;
    logic                  align_err;
    logic                  acc_err;
    logic                  enter_resp;
    logic                  do_write;
    logic [31:0]           rd_word;

    assign in_idle   = (state_q == S_IDLE);
    assign acc_we    = in_idle ? we      : we_q;
    assign acc_addr  = in_idle ? address : addr_q;
    assign acc_wdata = in_idle ? data_in : wdata_q;
    assign acc_be    = in_idle ? byte_en : be_q;

    assign word_idx  = acc_addr[ADDR_WIDTH+1:2];

    // Any set bit above the word-index field means the address lies
    // outside the RAM.
    assign range_err = ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);

`ifdef DM_UNALIGNED_ERR_EN
    assign align_err = (acc_addr[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

    assign acc_err    = range_err | align_err;

    // The RAM access and the result capture happen on the edge that
    // moves the FSM into RESP.
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    // Gating with reset keeps a write from committing on a clock edge
    // that occurs while reset is held.
    assign do_write   = enter_resp && acc_we && !acc_err && !reset;

    assign rd_word    = mem[word_idx];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Holds the FSM state and the wait counter; reset aborts any transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Sequences IDLE -> WAIT (WAIT_CYCLES cycles) -> RESP (one cycle) -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // ready/ack decode straight from the state; err is only shown while ack is high.
    always_comb begin
        ready       = (state_q == S_IDLE);
        ack         = (state_q == S_RESP);
        err         = (state_q == S_RESP) && err_q;
        data_out    = data_q;
        dbg_state_o = state_q;
    end

    // ------------------------------------------------------------------
    // Result path
    // ------------------------------------------------------------------
    // Next values of read data and error: rejected accesses return zero,
    // reads return the RAM word, and writes leave data_out untouched.
    always_comb begin
        data_d = data_q;
        err_d  = err_q;
        if (enter_resp) begin
            err_d = acc_err;
            if (acc_err) begin
                data_d = 32'd0;
            end else if (!acc_we) begin
                data_d = rd_word;
            end
        end
    end

    // Registers the response so that it stays stable through RESP and data_out holds afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    // Captures the request fields on the acceptance edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (in_idle && req) begin
            we_q    <= we;
            addr_q  <= address;
            wdata_q <= data_in;
            be_q    <= byte_en;
        end
    end

    // ------------------------------------------------------------------
    // RAM write port
    // ------------------------------------------------------------------
    // Byte-lane write. Only lanes whose byte_en bit is set are updated.
    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed testbench for dm_responder (ADDR_WIDTH=10, WAIT_CYCLES=2).
// Sampling is done on the falling edge and inputs change on the falling
// edge or #1 after the rising edge.

module tb_dm_responder;

  localparam int AW       = 10;
  localparam int WAITS    = 2;
  localparam int EXP_LAT  = WAITS + 1;   // falling edges from acceptance to ack
  localparam int EXP_GAP  = WAITS + 2;   // cycles between back-to-back acceptances

  logic        clock;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  byte_en;
  logic        ready;
  logic        ack;
  logic [31:0] data_out;
  logic        err;
  logic [1:0]  dbg_state_o;

  int checks;
  int errors;

  dm_responder #(
    .ADDR_WIDTH  (AW),
    .WAIT_CYCLES (WAITS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .address     (address),
    .data_in     (data_in),
    .byte_en     (byte_en),
    .ready       (ready),
    .ack         (ack),
    .data_out    (data_out),
    .err         (err),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver ----------------
  // Runs a single transaction. It returns the data and error seen with
  // ack, the number of falling edges from acceptance to ack (-1 if no
  // ack arrives within the budget), and ack/ready one cycle after the ack.
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr,
                         input logic [31:0] t_data, input logic [3:0] t_be,
                         output logic [31:0] o_data, output logic o_err,
                         output int o_lat, output logic o_ack_next,
                         output logic o_ready_next);
    int waited;
    o_data = 'x; o_err = 1'bx; o_lat = -1; o_ack_next = 1'bx; o_ready_next = 1'bx;
    @(negedge clock);
    we = t_we; address = t_addr; data_in = t_data; byte_en = t_be; req = 1'b1;
    waited = 0;
    while (ready !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (ready !== 1'b1) begin
      req = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    // Scramble the inputs after acceptance so the sampled copy is what counts.
    req = 1'b0; we = ~t_we; address = 32'h0000_0000; data_in = ~t_data; byte_en = 4'hF;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (ack === 1'b1) begin
        o_lat  = k;
        o_data = data_out;
        o_err  = err;
        @(negedge clock);
        o_ack_next   = ack;
        o_ready_next = ready;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; address = '0; data_in = '0; byte_en = '0;
    repeat (3) @(negedge clock);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", data_out); end
    checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state_o); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat; logic an; logic rn;
    run_txn(1'b1, 32'h10, 32'h1234_5678, 4'hF, d, e, lat, an, rn);
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL wr_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wr_data_held got %h want 00000000", d); end
    checks++; if (an !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", an); end
    checks++; if (rn !== 1'b1) begin errors++; $display("FAIL wr_ready_after got %b want 1", rn); end
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, d, e, lat, an, rn);
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL rd_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h want 12345678", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", e); end
    checks++; if (an !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse got %b want 0", an); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; logic e; int lat; logic an; logic rn;
    run_txn(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, d, e, lat, an, rn);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL be_wr_data_held got %h want 12345678", d); end
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, d, e, lat, an, rn);
    checks++; if (d !== 32'h12BB_56DD) begin errors++; $display("FAIL be_merge got %h want 12bb56dd", d); end
    run_txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, d, e, lat, an, rn);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL be_zero_err got %b want 0", e); end
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL be_zero_latency got %0d want %0d", lat, EXP_LAT); end
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, d, e, lat, an, rn);
    checks++; if (d !== 32'h12BB_56DD) begin errors++; $display("FAIL be_zero_nochange got %h want 12bb56dd", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic e; int lat; logic an; logic rn;
    run_txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, d, e, lat, an, rn);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b want 1", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h want 00000000", d); end
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL oor_latency got %0d want %0d", lat, EXP_LAT); end
    // 0x1010 aliases word 0x10 if the range check is missing.
    run_txn(1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'hF, d, e, lat, an, rn);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b want 1", e); end
    run_txn(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, d, e, lat, an, rn);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_msb_err got %b want 1", e); end
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, d, e, lat, an, rn);
    checks++; if (d !== 32'h12BB_56DD) begin errors++; $display("FAIL oor_ram_unchanged got %h want 12bb56dd", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL oor_err_cleared got %b want 0", e); end
  endtask

  task automatic test_unaligned();
    logic [31:0] d; logic e; int lat; logic an; logic rn;
    logic [31:0] exp_d; logic exp_e;
`ifdef DM_UNALIGNED_ERR_EN
    exp_d = 32'h0; exp_e = 1'b1;
`else
    exp_d = 32'h12BB_56DD; exp_e = 1'b0;
`endif
    run_txn(1'b0, 32'h13, 32'h0, 4'h0, d, e, lat, an, rn);
    checks++; if (e !== exp_e) begin errors++; $display("FAIL unaligned_err got %b want %b", e, exp_e); end
    checks++; if (d !== exp_d) begin errors++; $display("FAIL unaligned_data got %h want %h", d, exp_d); end
  endtask

  task automatic test_back_to_back();
    logic        t_we[3];
    logic [31:0] t_addr[3];
    logic [31:0] t_data[3];
    int acc_cyc[3];
    int ack_cyc[3];
    logic [31:0] ack_data[3];
    int n_acc; int n_ack; int ready_hi; int double_ack;
    logic prev_ack; logic acc_now;
    t_we   = '{1'b1, 1'b1, 1'b0};
    t_addr = '{32'h30, 32'h34, 32'h34};
    t_data = '{32'h1111_1111, 32'h2222_2222, 32'h0};
    n_acc = 0; n_ack = 0; ready_hi = 0; double_ack = 0; prev_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin acc_cyc[i] = -100; ack_cyc[i] = 100; ack_data[i] = 'x; end
    @(negedge clock);
    we = t_we[0]; address = t_addr[0]; data_in = t_data[0]; byte_en = 4'hF; req = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (ack === 1'b1) begin
        if (prev_ack) double_ack++;
        if (n_ack < 3) begin ack_cyc[n_ack] = cyc; ack_data[n_ack] = data_out; end
        n_ack++;
      end
      prev_ack = ack;
      acc_now = (ready === 1'b1) && (req === 1'b1);
      if (ready === 1'b1) ready_hi++;
      if (acc_now && n_acc < 3) begin acc_cyc[n_acc] = cyc; end
      if (acc_now) n_acc++;
      if (n_ack >= 3) break;
      @(posedge clock);
      #1;
      if (acc_now) begin
        if (n_acc < 3) begin
          we = t_we[n_acc]; address = t_addr[n_acc]; data_in = t_data[n_acc];
        end else begin
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    checks++; if (n_ack != 3) begin errors++; $display("FAIL b2b_ack_count got %0d want 3", n_ack); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != EXP_GAP) begin errors++; $display("FAIL b2b_gap01 got %0d want %0d", acc_cyc[1] - acc_cyc[0], EXP_GAP); end
    checks++; if (acc_cyc[2] - acc_cyc[1] != EXP_GAP) begin errors++; $display("FAIL b2b_gap12 got %0d want %0d", acc_cyc[2] - acc_cyc[1], EXP_GAP); end
    checks++; if (ready_hi != 3) begin errors++; $display("FAIL b2b_ready_high got %0d want 3", ready_hi); end
    checks++; if (double_ack != 0) begin errors++; $display("FAIL b2b_ack_width got %0d want 0", double_ack); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ack_cyc[i] - acc_cyc[i] != EXP_LAT) begin
        errors++; $display("FAIL b2b_latency%0d got %0d want %0d", i, ack_cyc[i] - acc_cyc[i], EXP_LAT);
      end
    end
    checks++; if (ack_data[2] !== 32'h2222_2222) begin errors++; $display("FAIL b2b_raw_data got %h want 22222222", ack_data[2]); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat; logic an; logic rn;
    int stray_ack;
    run_txn(1'b1, 32'h20, 32'h5A5A_5A5A, 4'hF, d, e, lat, an, rn);
    @(negedge clock);
    we = 1'b1; address = 32'h20; data_in = 32'hDEAD_BEEF; byte_en = 4'hF; req = 1'b1;
    @(posedge clock);
    #1;
    req = 1'b0;
    checks++; if (dbg_state_o !== 2'd1) begin errors++; $display("FAIL rstmid_in_wait got %0d want 1", dbg_state_o); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", ready); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %b want 0", ack); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h want 00000000", data_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", err); end
    stray_ack = 0;
    repeat (3) begin @(negedge clock); if (ack === 1'b1) stray_ack++; end
    reset = 1'b0;
    repeat (5) begin @(negedge clock); if (ack === 1'b1) stray_ack++; end
    checks++; if (stray_ack != 0) begin errors++; $display("FAIL rstmid_no_ack got %0d want 0", stray_ack); end
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, d, e, lat, an, rn);
    checks++; if (d !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rstmid_not_committed got %h want 5a5a5a5a", d); end
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL rstmid_read_latency got %0d want %0d", lat, EXP_LAT); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_unaligned();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run always ends even if a task misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
